alu_share_ctrl: RTL and testbench
=================================

// Module: alu_share_ctrl
// PURPOSE
//  Shares one 8-bit combinational ALU (ADD/SUB/AND/OR/XOR; carry_out, zero,
//  overflow flags) between N_REQ requesters using round-robin arbitration.
//  Each command is accepted through a valid/ready handshake, executed on the
//  internal ALU from registered operands, and returned on one registered
//  response channel tagged with the requester ID.
// PARAMETERS
//  N_REQ   2  number of requesters; legal range 2..8
//  ID_W    $clog2(N_REQ)  width of rsp_id; derived, do not override
// PORTS
//  clk           in   1          rising-edge clock
//  rst_n         in   1          asynchronous active-low reset
//  req_valid     in   N_REQ      per-requester command valid
//  req_ready     out  N_REQ      per-requester accept (one-hot or zero)
//  req_op        in   3*N_REQ    opcode; slice [3*i+:3] belongs to requester i
//  req_a         in   8*N_REQ    operand A; slice [8*i+:8]
//  req_b         in   8*N_REQ    operand B; slice [8*i+:8]
//  rsp_valid     out  1          response valid
//  rsp_ready     in   1          response accept
//  rsp_id        out  ID_W       index of the requester that issued the command
//  rsp_result    out  8          ALU result
//  rsp_carry     out  1          ALU carry_out (SUB: 1 = no borrow)
//  rsp_zero      out  1          ALU zero flag
//  rsp_overflow  out  1          ALU signed-overflow flag
//  rsp_err       out  1          illegal opcode (3'b101..3'b111)
// BEHAVIOUR
//  Reset: state=IDLE; rr pointer=0 (req0 highest priority); req_ready=0;
//    rsp_valid=0; rsp_id=0; rsp_result=8'h00; all flags=0; rsp_err=0.
//  FSM IDLE -> EXEC -> RESP -> IDLE.
//   IDLE: if any req_valid, pick winner g by round-robin, starting at the rr
//     pointer. Drive req_ready[g]=1 combinationally in this cycle only.
//     Capture op/a/b/g into registers; go EXEC. With no request, stay IDLE.
//   EXEC: the ALU sees only the captured operands. Register its result and
//     flags into the rsp_* registers; set rsp_valid=1; pointer <= g+1 (mod
//     N_REQ); go RESP.
//   RESP: all rsp_* outputs held stable while rsp_valid && !rsp_ready.
//     When rsp_ready=1: rsp_valid=0 next cycle; go IDLE.
//  req_ready is 0 in EXEC and RESP.
//  Latency: accept at cycle T -> rsp_valid at T+2. Minimum spacing between
//    accepts is 3 cycles (RESP with immediate rsp_ready).
//  Illegal op: command is accepted normally; the ALU result is ignored.
//    Response gives rsp_err=1, result=00, carry/zero/overflow=0, same latency.
//  Arithmetic is exactly the ALU's:
//    ADD: {c,r}=a+b.  SUB: {c,r}=a+~b+1.
//    Logic ops force carry=0 and overflow=0.  zero = (r==0) for legal ops.
//  Simultaneous requests: exactly one granted per accept. A requester that
//    holds valid is served within N_REQ accepts.
//  A req_valid dropped while not granted is ignored (no state kept).
//  Reset asserted in any state: the in-flight command is discarded and all
//    outputs return to reset values asynchronously. No response is issued
//    after reset deassertion.
// STRUCTURE
//  alu_pkg: typedef enum logic[2:0] alu_op_e {ALU_ADD=0, ALU_SUB=1,
//    ALU_AND=2, ALU_OR=3, ALU_XOR=4}; typedef enum ctrl_state_e
//    {IDLE, EXEC, RESP}; localparam ALU_W=8; function is_legal_op().
//  Sub-modules: the existing alu is instantiated once. rr_arbiter #(N_REQ)
//    takes req and pointer and returns one-hot grant plus index.
//  The pointer update stays in this block.
// TESTING
//  1 req0 ADD 7F+02 -> T+2: rsp_id=0, result=81, ovf=1, carry=0, zero=0.
//  2 req1 ADD FF+01, then req1 SUB 00-01 -> result=00 carry=1 zero=1;
//    then result=FF carry=0 ovf=0.
//  3 both valid from reset, held -> grants 0,1,0,1. Both XOR 25^62 -> 47.
//  4 rsp_ready=0 for 4 cycles in RESP -> rsp_* stable, req_ready stays 0.
//  5 req0 op=3'b111 -> rsp_err=1, result=00, flags=0, normal latency.
//  6 rst_n low during EXEC -> rsp_valid=0 immediately; after release the
//    next request from req0 wins first.
//  Bench: scoreboard against a reference model; assert req_ready is one-hot
//    or zero, and rsp stable under backpressure.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the time-shared ALU controller.
// Contents:
//   ALU_W         operand and result width
//   alu_op_e      ALU opcodes; encodings 3'b101..3'b111 are illegal
//   ctrl_state_e  controller states IDLE -> EXEC -> RESP
//   is_legal_op   1 when an opcode maps onto a real ALU operation
package alu_pkg;

    localparam int ALU_W = 8;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } ctrl_state_e;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op <= ALU_XOR);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU: ADD, SUB, AND, OR, XOR with carry, zero and
// signed-overflow flags.
// Ports:
//   op        in   3      opcode (alu_op_e encoding)
//   a, b      in   ALU_W  operands
//   result    out  ALU_W  operation result (0 for an illegal opcode)
//   carry     out  1      carry out; for SUB 1 means no borrow
//   zero      out  1      result == 0
//   overflow  out  1      two's-complement overflow (ADD/SUB only)
module alu
    import alu_pkg::*;
(
    input  logic [2:0]       op,
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    output logic [ALU_W-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             overflow
);

    localparam int MSB = ALU_W - 1;

    logic [ALU_W:0] sum;

    always_comb begin
        sum      = '0;
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (alu_op_e'(op))
            ALU_ADD: begin
                sum      = {1'b0, a} + {1'b0, b};
                result   = sum[MSB:0];
                carry    = sum[ALU_W];
                overflow = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
            end
            ALU_SUB: begin
                // Subtract as a + ~b + 1 so carry reads as "no borrow".
                sum      = {1'b0, a} + {1'b0, ~b} + {{ALU_W{1'b0}}, 1'b1};
                result   = sum[MSB:0];
                carry    = sum[ALU_W];
                overflow = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The search starts at ptr and wraps,
// so the requester at ptr has highest priority.
// Ports:
//   req    in   N_REQ  request vector
//   ptr    in   ID_W   index with highest priority this cycle (< N_REQ)
//   grant  out  N_REQ  one-hot grant, zero when no request
//   idx    out  ID_W   index of the granted requester
//   any    out  1      at least one request present
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!any && req[(int'(ptr) + k) % N_REQ]) begin
                any                               = 1'b1;
                grant[(int'(ptr) + k) % N_REQ]    = 1'b1;
                idx                               = ID_W'((int'(ptr) + k) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU between N_REQ requesters. A round-robin winner is accepted
// in IDLE, its command executes from registered operands in EXEC, and the
// registered, ID-tagged response is held in RESP until rsp_ready.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   req_valid     per-requester command valid
//   req_ready     per-requester accept (one-hot or zero, IDLE only)
//   req_op/a/b    packed per-requester opcode [3*i+:3], operands [8*i+:8]
//   rsp_valid     response valid, held until rsp_ready
//   rsp_ready     response accept
//   rsp_id        requester index of the response
//   rsp_result    ALU result (0 for an illegal opcode)
//   rsp_carry/zero/overflow  ALU flags (0 for an illegal opcode)
//   rsp_err       opcode was illegal
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [3*N_REQ-1:0]     req_op,
    input  logic [ALU_W*N_REQ-1:0] req_a,
    input  logic [ALU_W*N_REQ-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [ALU_W-1:0]       rsp_result,
    output logic                   rsp_carry,
    output logic                   rsp_zero,
    output logic                   rsp_overflow,
    output logic                   rsp_err
);

    ctrl_state_e state;
    logic [ID_W-1:0] ptr;

    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_idx;
    logic             grant_any;

    logic [2:0]       op_p0;
    logic [ALU_W-1:0] a_p0;
    logic [ALU_W-1:0] b_p0;
    logic [ID_W-1:0]  id_p0;

    logic [ALU_W-1:0] alu_result;
    logic             alu_carry;
    logic             alu_zero;
    logic             alu_overflow;

    logic accept;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    // Grants are only offered while idle; the winner sees ready for one cycle.
    assign req_ready = (state == IDLE) ? grant : '0;
    assign accept    = (state == IDLE) && grant_any;

    // Stage p0: capture the winning command; the ALU only ever sees these.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0 <= req_op[3*grant_idx +: 3];
            a_p0  <= req_a[ALU_W*grant_idx +: ALU_W];
            b_p0  <= req_b[ALU_W*grant_idx +: ALU_W];
            id_p0 <= grant_idx;
        end
    end

    alu u_alu (
        .op       (op_p0),
        .a        (a_p0),
        .b        (b_p0),
        .result   (alu_result),
        .carry    (alu_carry),
        .zero     (alu_zero),
        .overflow (alu_overflow)
    );

    // Stage p1: controller and registered response channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_result   <= '0;
            rsp_carry    <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= id_p0;
                    if (is_legal_op(op_p0)) begin
                        rsp_result   <= alu_result;
                        rsp_carry    <= alu_carry;
                        rsp_zero     <= alu_zero;
                        rsp_overflow <= alu_overflow;
                        rsp_err      <= 1'b0;
                    end else begin
                        rsp_result   <= '0;
                        rsp_carry    <= 1'b0;
                        rsp_zero     <= 1'b0;
                        rsp_overflow <= 1'b0;
                        rsp_err      <= 1'b1;
                    end
                    // The requester just served drops to lowest priority.
                    ptr   <= (int'(id_p0) == N_REQ - 1) ? '0 : id_p0 + 1'b1;
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
module tb_alu_share_ctrl;

    localparam int N  = 2;
    localparam int IW = $clog2(N);

    typedef struct packed {
        logic [7:0] id;
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       o;
        logic       e;
    } rsp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [3*N-1:0] req_op;
    logic [8*N-1:0] req_a;
    logic [8*N-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IW-1:0]  rsp_id;
    logic [7:0]     rsp_result;
    logic           rsp_carry;
    logic           rsp_zero;
    logic           rsp_overflow;
    logic           rsp_err;

    logic       rv  [N];
    logic [2:0] rop [N];
    logic [7:0] ra  [N];
    logic [7:0] rb  [N];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rsp_cnt = 0;
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: never ready

    rsp_t exp_q[$];
    int   acc_q[$];
    int   glog[$];
    rsp_t last_rsp;

    int   start = 0;
    bit   busy = 0;
    bit   in_rsp = 0;
    bit   hold = 0;
    rsp_t snap;

    alu_share_ctrl #(.N_REQ(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_carry    (rsp_carry),
        .rsp_zero     (rsp_zero),
        .rsp_overflow (rsp_overflow),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < N; i++) begin
            req_valid[i]     = rv[i];
            req_op[3*i +: 3] = rop[i];
            req_a[8*i +: 8]  = ra[i];
            req_b[8*i +: 8]  = rb[i];
        end
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = ($urandom_range(0, 9) < 6);
            default: rsp_ready = 1'b0;
        endcase
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic rsp_t dut_rsp();
        rsp_t r;
        r.id  = 8'(rsp_id);
        r.res = rsp_result;
        r.c   = rsp_carry;
        r.z   = rsp_zero;
        r.o   = rsp_overflow;
        r.e   = rsp_err;
        return r;
    endfunction

    // Reference model from plain integer arithmetic.
    function automatic rsp_t ref_model(input int id, input logic [2:0] op,
                                       input logic [7:0] a, input logic [7:0] b);
        rsp_t r;
        int ua = a;
        int ub = b;
        int sa = $signed(a);
        int sb = $signed(b);
        int s;
        r = '0;
        r.id = 8'(id);
        case (op)
            3'd0: begin
                r.res = 8'((ua + ub) % 256);
                r.c   = (ua + ub) > 255;
                s     = sa + sb;
                r.o   = (s > 127) || (s < -128);
            end
            3'd1: begin
                r.res = 8'((ua - ub + 256) % 256);
                r.c   = (ua >= ub);
                s     = sa - sb;
                r.o   = (s > 127) || (s < -128);
            end
            3'd2: r.res = a & b;
            3'd3: r.res = a | b;
            3'd4: r.res = a ^ b;
            default: r.e = 1'b1;
        endcase
        r.z = !r.e && (r.res == 8'h00);
        return r;
    endfunction

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            acc_q.delete();
            busy   = 0;
            in_rsp = 0;
            hold   = 0;
            start  = 0;
        end else begin
            logic [N-1:0] eg;
            int w;
            int g;
            eg = '0;
            if (!busy) begin
                for (int k = 0; k < N; k++) begin
                    w = (start + k) % N;
                    if (rv[w]) begin
                        eg[w] = 1'b1;
                        break;
                    end
                end
            end
            chk("req_ready", int'(req_ready), int'(eg));
            chk("req_ready_onehot0", int'($onehot0(req_ready)), 1);
            if (req_ready != '0) begin
                g = 0;
                for (int k = 0; k < N; k++) if (req_ready[k]) g = k;
                exp_q.push_back(ref_model(g, rop[g], ra[g], rb[g]));
                acc_q.push_back(cyc);
                glog.push_back(g);
                start = (g + 1) % N;
                busy  = 1;
            end
            if (hold) begin
                chk("hold_valid", int'(rsp_valid), 1);
                chk("hold_data", int'(dut_rsp()), int'(snap));
            end
            if (rsp_valid && !in_rsp) begin
                in_rsp = 1;
                if (acc_q.size() > 0) chk("latency", cyc - acc_q.pop_front(), 2);
                else fail("spurious_rsp_valid");
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() > 0) chk("rsp", int'(dut_rsp()), int'(exp_q.pop_front()));
                else fail("unexpected_rsp");
                last_rsp = dut_rsp();
                in_rsp   = 0;
                busy     = 0;
                rsp_cnt++;
            end
            hold = rsp_valid && !rsp_ready;
            snap = dut_rsp();
        end
    end

    task automatic issue(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        rv[i] = 1'b1; rop[i] = op; ra[i] = a; rb[i] = b;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[i] && n < 200);
        if (!req_ready[i]) fail("accept_timeout");
        @(posedge clk);
        #1;
        rv[i] = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        int n = 0;
        while (rsp_cnt < target && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (rsp_cnt < target) fail("rsp_timeout");
        #1;
    endtask

    task automatic chk_last(input string name, input int id, input logic [7:0] res,
                            input logic c, input logic z, input logic o, input logic e);
        rsp_t r;
        r.id = 8'(id); r.res = res; r.c = c; r.z = z; r.o = o; r.e = e;
        chk(name, int'(last_rsp), int'(r));
    endtask

    task automatic rnd_driver(input int i);
        repeat (25) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            issue(i, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n0;
        for (int i = 0; i < N; i++) begin
            rv[i] = 1'b0; rop[i] = '0; ra[i] = '0; rb[i] = '0;
        end
        rsp_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", int'(req_ready), 0);
        chk("reset_rsp", int'({rsp_valid, dut_rsp()}), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADD with signed overflow
        n0 = rsp_cnt;
        issue(0, 3'd0, 8'h7F, 8'h02);
        wait_rsp(n0 + 1);
        chk_last("add_7f_02", 0, 8'h81, 0, 0, 1, 0);

        // ADD wrap to zero, SUB with borrow
        n0 = rsp_cnt;
        issue(1, 3'd0, 8'hFF, 8'h01);
        wait_rsp(n0 + 1);
        chk_last("add_ff_01", 1, 8'h00, 1, 1, 0, 0);
        issue(1, 3'd1, 8'h00, 8'h01);
        wait_rsp(n0 + 2);
        chk_last("sub_00_01", 1, 8'hFF, 0, 0, 0, 0);

        // Both requesters contending: alternate grants
        glog.delete();
        n0 = rsp_cnt;
        fork
            issue(0, 3'd4, 8'h25, 8'h62);
            issue(1, 3'd4, 8'h25, 8'h62);
        join
        fork
            issue(0, 3'd4, 8'h25, 8'h62);
            issue(1, 3'd4, 8'h25, 8'h62);
        join
        wait_rsp(n0 + 4);
        chk("rr_grants", glog.size() == 4 ? (glog[0] << 12 | glog[1] << 8 | glog[2] << 4 | glog[3]) : -1,
            32'h0101);
        chk_last("xor_25_62", 1, 8'h47, 0, 0, 0, 0);

        // Backpressure with another request pending
        n0 = rsp_cnt;
        rdy_mode = 2;
        issue(0, 3'd3, 8'h0F, 8'hF0);
        fork
            issue(1, 3'd2, 8'h3C, 8'hF0);
        join_none
        repeat (6) @(posedge clk);
        #1;
        chk("bp_no_rsp_taken", rsp_cnt, n0);
        rdy_mode = 0;
        wait_rsp(n0 + 2);
        chk_last("and_3c_f0", 1, 8'h30, 0, 0, 0, 0);

        // Illegal opcode
        n0 = rsp_cnt;
        issue(0, 3'b111, 8'h12, 8'h34);
        wait_rsp(n0 + 1);
        chk_last("illegal_op", 0, 8'h00, 0, 0, 0, 1);

        // Reset while a command is executing
        issue(1, 3'd0, 8'h01, 8'h01);
        issue(0, 3'd0, 8'h01, 8'h01);
        rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_outputs", int'({req_ready, dut_rsp()}), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n0 = rsp_cnt;
        repeat (4) @(posedge clk);
        #1;
        chk("no_rsp_after_reset", rsp_cnt, n0);
        glog.delete();
        fork
            issue(1, 3'd1, 8'h10, 8'h01);
            issue(0, 3'd1, 8'h10, 8'h01);
        join
        wait_rsp(n0 + 2);
        chk("first_grant_after_reset", glog.size() > 0 ? glog[0] : -1, 0);

        // Random traffic with random backpressure
        rdy_mode = 1;
        fork
            rnd_driver(0);
            rnd_driver(1);
        join
        rdy_mode = 0;
        begin
            int n = 0;
            while (exp_q.size() > 0 && n < 100) begin
                @(posedge clk);
                n++;
            end
        end
        #1;
        chk("drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
